// File: rtl/ft601_tx_arbiter.sv
// ft601_tx_arbiter
// Round-robin arbiter that frames peripheral bursts for the FT601 bus
// controller. Each grant produces one header word followed by a payload
// burst of L words, where L is the channel's committed count capped at
// MAX_BURST. The result is presented on a single registered word stream
// with a valid/ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | scan requesters from rr_ptr; load header when the slot is free
// PAYLOAD | pop granted channel words until remaining reaches zero
module ft601_tx_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 16,
  parameter int AVAIL_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*32-1:0]      periph_data,
  input  logic [NUM_CH*4-1:0]       periph_be,
  input  logic [NUM_CH-1:0]         periph_valid,
  input  logic [NUM_CH*AVAIL_W-1:0] periph_avail,
  output logic [NUM_CH-1:0]         periph_ready,
  output logic [31:0]               tx_data,
  output logic [3:0]                tx_be,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CMP_W = (AVAIL_W > 8) ? AVAIL_W : 8;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;

  localparam logic [7:0]       HDR_TAG = 8'hA5;
  localparam logic [7:0]       MAX_L   = 8'(MAX_BURST);
  localparam logic [CMP_W-1:0] MAX_CMP = CMP_W'(MAX_BURST);

  logic [0:0]         state;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant;
  logic [7:0]         remaining;

  logic               req_found;
  logic [CH_W-1:0]    req_sel;
  logic [AVAIL_W-1:0] req_avail;
  logic [7:0]         req_len;
  logic [31:0]        hdr_word;

  logic [31:0]        sel_data;
  logic [3:0]         sel_be;
  logic               sel_valid;

  logic               slot_free;
  logic               burst_open;
  logic               load_hdr;
  logic               pop;

  // Next channel index after v, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] v);
    return CH_W'((int'(v) + 1) % NUM_CH);
  endfunction

  // Output slot can take a word when empty or when its word leaves this cycle.
  assign slot_free  = !tx_valid || tx_ready;
  assign burst_open = (state == S_PAYLOAD) && (remaining != 8'd0);
  assign load_hdr   = (state == S_IDLE) && req_found && slot_free;
  assign pop        = burst_open && slot_free && sel_valid;

  // Round-robin scan: first channel with a nonzero commitment, starting at rr_ptr.
  always_comb begin : arb_scan
    int idx;
    req_found = 1'b0;
    req_sel   = '0;
    req_avail = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!req_found && (periph_avail[idx*AVAIL_W +: AVAIL_W] != '0)) begin
        req_found = 1'b1;
        req_sel   = CH_W'(idx);
        req_avail = periph_avail[idx*AVAIL_W +: AVAIL_W];
      end
    end
  end

  // Burst length is the commitment capped at MAX_BURST; the rest waits for a later grant.
  always_comb begin
    if (CMP_W'(req_avail) > MAX_CMP) begin
      req_len = MAX_L;
    end else begin
      req_len = 8'(req_avail);
    end
  end

  // Header layout: tag, channel id, zero nibble, burst length, zero byte.
  assign hdr_word = {HDR_TAG, 4'(req_sel), 4'h0, req_len, 8'h00};

  // Mux the granted channel's word onto the payload path.
  always_comb begin
    sel_data  = '0;
    sel_be    = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_data  = periph_data[32*i +: 32];
        sel_be    = periph_be[4*i +: 4];
        sel_valid = periph_valid[i];
      end
    end
  end

  // Pop strobe goes only to the granted channel and only while the slot can accept.
  always_comb begin
    periph_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (burst_open && slot_free && (grant == CH_W'(i))) begin
        periph_ready[i] = 1'b1;
      end
    end
  end

  // Grant sequencing: latch the winner and its length, count payload words down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      remaining <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_hdr) begin
            grant     <= req_sel;
            remaining <= req_len;
            state     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (pop) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state  <= S_IDLE;
              rr_ptr <= next_ch(grant);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Single-entry output register; holds its word while the controller stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 32'd0;
      tx_be    <= 4'd0;
    end else if (load_hdr) begin
      tx_valid <= 1'b1;
      tx_data  <= hdr_word;
      tx_be    <= 4'hF;
    end else if (pop) begin
      tx_valid <= 1'b1;
      tx_data  <= sel_data;
      tx_be    <= sel_be;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ft601_tx_arbiter.sv
// Bench for ft601_tx_arbiter: channel queues drive the DUT, and a
// transaction-level model predicts the complete framed output stream.
module tb_ft601_tx_arbiter;

  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 16;
  localparam int AVAIL_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_CH*32-1:0]      periph_data;
  logic [NUM_CH*4-1:0]       periph_be;
  logic [NUM_CH-1:0]         periph_valid;
  logic [NUM_CH*AVAIL_W-1:0] periph_avail;
  logic [NUM_CH-1:0]         periph_ready;
  logic [31:0]               tx_data;
  logic [3:0]                tx_be;
  logic                      tx_valid;
  logic                      tx_ready;

  always #5 clk = ~clk;

  ft601_tx_arbiter #(
    .NUM_CH(NUM_CH),
    .MAX_BURST(MAX_BURST),
    .AVAIL_W(AVAIL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .periph_data(periph_data),
    .periph_be(periph_be),
    .periph_valid(periph_valid),
    .periph_avail(periph_avail),
    .periph_ready(periph_ready),
    .tx_data(tx_data),
    .tx_be(tx_be),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] q_data [NUM_CH][$];
  logic [3:0]  q_be   [NUM_CH][$];
  logic [31:0] exp_data [$];
  logic [3:0]  exp_be   [$];
  int          model_rr = 0;
  int          ready_pct = 100;
  int          valid_pct = 100;
  bit          valid_block = 1'b0;
  int          pop_cnt [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present each channel's queue head, its remaining commitment and the consumer's ready.
  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      int n;
      n = q_data[c].size();
      periph_avail[c*AVAIL_W +: AVAIL_W] = AVAIL_W'((n > 255) ? 255 : n);
      if (n > 0) begin
        periph_data[c*32 +: 32] = q_data[c][0];
        periph_be[c*4 +: 4]     = q_be[c][0];
        periph_valid[c]         = !valid_block && (int'($urandom_range(99)) < valid_pct);
      end else begin
        periph_data[c*32 +: 32] = 32'd0;
        periph_be[c*4 +: 4]     = 4'd0;
        periph_valid[c]         = 1'b0;
      end
    end
    tx_ready = (int'($urandom_range(99)) < ready_pct);
  endtask

  // One clock: observe handshakes before the edge, apply their effects after it.
  task automatic cycle();
    logic              acc;
    logic [31:0]       d;
    logic [3:0]        b;
    logic [NUM_CH-1:0] pr;
    logic [NUM_CH-1:0] pv;
    @(negedge clk);
    acc = tx_valid && tx_ready && !rst;
    d   = tx_data;
    b   = tx_be;
    pr  = periph_ready;
    pv  = periph_valid;
    @(posedge clk);
    #1;
    if (acc) begin
      if (exp_data.size() == 0) begin
        chk("extra_word", 32'(exp_data.size()), 32'd1);
      end else begin
        chk("tx_data", d, exp_data.pop_front());
        chk("tx_be", 32'(b), 32'(exp_be.pop_front()));
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (pr[c] && pv[c] && q_data[c].size() > 0) begin
        pop_cnt[c]++;
        void'(q_data[c].pop_front());
        void'(q_be[c].pop_front());
      end
    end
    drive_inputs();
  endtask

  task automatic add_word(input int c, input logic [31:0] d, input logic [3:0] b);
    q_data[c].push_back(d);
    q_be[c].push_back(b);
  endtask

  task automatic add_random(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      add_word(c, $urandom, 4'($urandom_range(15)));
    end
  endtask

  // Predict the framed stream for everything now queued: fair rotation, capped bursts.
  task automatic model_batch();
    int cnt [NUM_CH];
    int pos [NUM_CH];
    int left;
    int g;
    int len;
    left = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c] = q_data[c].size();
      pos[c] = 0;
      left  += cnt[c];
    end
    while (left > 0) begin
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (g < 0 && cnt[(model_rr + k) % NUM_CH] > 0) g = (model_rr + k) % NUM_CH;
      end
      len = (cnt[g] < MAX_BURST) ? cnt[g] : MAX_BURST;
      exp_data.push_back(32'hA500_0000 | (32'(g) << 20) | (32'(len) << 8));
      exp_be.push_back(4'hF);
      for (int i = 0; i < len; i++) begin
        exp_data.push_back(q_data[g][pos[g] + i]);
        exp_be.push_back(q_be[g][pos[g] + i]);
      end
      pos[g]  += len;
      cnt[g]  -= len;
      left    -= len;
      model_rr = (g + 1) % NUM_CH;
    end
    drive_inputs();
  endtask

  task automatic run_drain(input string tag, input int budget, output int cycles);
    int qleft;
    cycles = 0;
    while (exp_data.size() != 0 && cycles < budget) begin
      cycle();
      cycles++;
    end
    qleft = 0;
    for (int c = 0; c < NUM_CH; c++) qleft += q_data[c].size();
    chk({tag, "_timeout"}, 32'(exp_data.size()), 32'd0);
    chk({tag, "_queues"}, 32'(qleft), 32'd0);
    chk({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(periph_ready), 32'd0);
  endtask

  initial begin
    int n0;
    int cyc;
    int p0;
    for (int c = 0; c < NUM_CH; c++) pop_cnt[c] = 0;
    rst = 1'b1;
    drive_inputs();
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_tx_be", 32'(tx_be), 32'd0);
    chk("rst_periph_ready", 32'(periph_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();

    // Single channel, three words, full speed: header one cycle after request.
    add_word(0, 32'h1111_1111, 4'hF);
    add_word(0, 32'h2222_2222, 4'hF);
    add_word(0, 32'h3333_3333, 4'hF);
    model_batch();
    n0 = exp_data.size();
    cycle();
    chk("a_hdr_valid", 32'(tx_valid), 32'd1);
    chk("a_hdr_data", tx_data, 32'hA500_0300);
    run_drain("a", 100, cyc);
    chk("a_cycles", 32'(cyc + 1), 32'(n0 + 1));
    chk("a_pops", 32'(pop_cnt[0]), 32'd3);

    // Two requesters: bursts follow each other with no bubble.
    add_random(1, 2);
    add_random(2, 2);
    model_batch();
    n0 = exp_data.size();
    run_drain("b", 100, cyc);
    chk("b_cycles", 32'(cyc), 32'(n0 + 1));

    // Long commitment splits; a competing channel is served between the pieces.
    add_random(3, 20);
    add_random(0, 2);
    model_batch();
    n0 = exp_data.size();
    run_drain("c", 200, cyc);
    chk("c_cycles", 32'(cyc), 32'(n0 + 1));

    // Consumer stalls while the header is valid.
    ready_pct = 0;
    add_random(1, 3);
    model_batch();
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", tx_data, 32'hA510_0300);
      chk("stall_ready", 32'(periph_ready), 32'd0);
      cycle();
    end
    ready_pct = 100;
    drive_inputs();
    run_drain("stall", 100, cyc);

    // Granted channel drops valid mid-burst; stream drains and then resumes.
    p0 = pop_cnt[2];
    add_random(2, 6);
    model_batch();
    repeat (3) cycle();
    valid_block = 1'b1;
    drive_inputs();
    repeat (3) cycle();
    chk("bubble_valid", 32'(tx_valid), 32'd0);
    chk("bubble_pops", 32'(pop_cnt[2] - p0), 32'd2);
    valid_block = 1'b0;
    drive_inputs();
    run_drain("bubble", 100, cyc);
    chk("bubble_total", 32'(pop_cnt[2] - p0), 32'd6);

    // Randomized batches with random backpressure on both sides.
    for (int t = 0; t < 15; t++) begin
      ready_pct = int'($urandom_range(40, 100));
      valid_pct = int'($urandom_range(40, 100));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(3) != 0) add_random(c, int'($urandom_range(1, 30)));
      end
      model_batch();
      run_drain("rand", 5000, cyc);
    end

    // Reset in the middle of a burst; arbitration restarts from channel 0.
    ready_pct = 100;
    valid_pct = 100;
    add_random(1, 4);
    model_batch();
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_ready", 32'(periph_ready), 32'd0);
    chk("mid_rst_data", tx_data, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      q_data[c].delete();
      q_be[c].delete();
    end
    exp_data.delete();
    exp_be.delete();
    model_rr = 0;
    drive_inputs();
    repeat (2) cycle();
    rst = 1'b0;
    add_random(2, 2);
    add_random(0, 2);
    model_batch();
    cycle();
    chk("post_rst_hdr", tx_data, 32'hA500_0200);
    run_drain("post_rst", 100, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
